fifo_word_packer: RTL and testbench
===================================

# fifo_word_packer

Read-domain consumer placed directly downstream of `async_fifo`. It drains the FIFO's byte-wide read port and packs LANES consecutive entries into one wide word. The word goes out on a valid/ready stream, with a byte-keep mask and a flush path that emits partial words. It runs entirely on the FIFO read clock.

## Interface
Parameters:
- DATA_WIDTH, 8, width of one FIFO entry (one lane)
- LANES, 4, entries per output word; power of two, ≥2

Ports:
- read_clk  in  1  clock, shared with async_fifo read side
- read_reset_n  in  1  asynchronous active-low reset
- fifo_empty  in  1  async_fifo empty flag
- fifo_data  in  DATA_WIDTH  async_fifo read_data; show-ahead, valid whenever fifo_empty=0
- fifo_read_en  out  1  pop request to async_fifo read_en; entry consumed on the rising edge
- flush  in  1  single-cycle request to emit the partially filled word
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accept
- out_data  out  DATA_WIDTH*LANES  packed word; lane 0 = bits [DATA_WIDTH-1:0], first-popped entry
- out_keep  out  LANES  per-lane valid mask
- out_last  out  1  beat produced by a flush
- flush_busy  out  1  flush accepted, not yet completed

## Operation
- State: accumulator (LANES-1 lanes), lane_idx (0..LANES-1), output register, flush_pending.
- out_free = !out_valid || out_ready.
- pop = !fifo_empty && !flush_pending && (lane_idx < LANES-1 || out_free). fifo_read_en = pop, forced 0 while read_reset_n=0.
- Pop with lane_idx < LANES-1: fifo_data goes to lane lane_idx; lane_idx increments.
- Pop with lane_idx = LANES-1: output register loads {fifo_data, accumulator}, keep all ones, last=0, out_valid=1; lane_idx returns to 0.
- Output register is overwritten only when out_free. While out_valid && !out_ready, out_data, out_keep and out_last hold stable.
- An accepted beat with no new load clears out_valid to 0.
- A flush pulse sets flush_pending, which suppresses pops from the next cycle.
- Flush while a full-word pop completes in the same cycle: the pop wins, then flush is evaluated with lane_idx=0.
- flush_pending && lane_idx>0 && out_free: load the partial word, with unused lanes zeroed, keep = (1<<lane_idx)-1, last=1. Then clear lane_idx and flush_pending.
- flush_pending && lane_idx=0: clear flush_pending, no beat emitted.
- A flush pulse while flush_pending=1 is ignored.
- Reset mid-word discards accumulated entries; they were already popped and are lost by design.

## Timing
- Reset values: out_valid=0, out_data=0, out_keep=0, out_last=0, flush_busy=0, fifo_read_en=0, lane_idx=0.
- fifo_read_en is combinational from registered state, fifo_empty and out_ready.
- Latency: the final lane is popped at edge N and out_valid=1 after edge N.
- Throughput: one entry per cycle. With out_ready held high and the FIFO non-empty, one word every LANES cycles with no bubbles.
- Backpressure: with the output register blocked, up to LANES-1 more entries are popped, then pop stalls at lane_idx=LANES-1.
- Flush completes on the first edge where out_free holds; flush_busy = flush_pending, registered.
- FIFO empty gaps between entries change timing only, never packing order.

## Structure
- Shared package fifo_pack_pkg: integer clog2 function (same definition as the async_fifo bench), default LANES, LANE_IDX_W = clog2(LANES), keep-mask helper function.
- Flat single module; no sub-module is warranted.

## Test plan
- Full word: entries 0x00,0x44,0x88,0xCC with out_ready=1 -> one beat 0xCC884400, keep=4'hF, last=0, the cycle after the fourth pop.
- Backpressure: entries 0x01..0x08 with out_ready=0 -> 0x04030201 held stable; fifo_read_en=0 after 0x05..0x07 are popped. Raising out_ready -> 0x08070605 on the next beat.
- Partial flush: entries 0xA1,0xB2 then flush -> 0x0000B2A1, keep=4'h3, last=1; flush_busy high until that edge.
- Empty flush: flush with lane_idx=0 -> no beat; flush_busy high exactly one cycle.
- Flush blocked: output held with out_ready=0, 3 entries accumulated, then flush -> no pops. out_ready=1 -> first beat is the held word, second beat is the partial word with keep=4'h7.
- Reset mid-word: 2 entries popped, then read_reset_n pulsed low -> all outputs 0. The next 4 entries 0x10..0x13 -> 0x13121110, keep=4'hF.

Source files
------------

// File: rtl/fifo_pack_pkg.sv
// ----------------------------------------------------------------------------
// fifo_pack_pkg
// Shared definitions for the FIFO word packer and its neighbours:
//   - clog2          : integer ceiling log2 for sizing index fields
//   - DEFAULT_*      : default entry width and lane count
//   - LANE_IDX_W     : lane index width for the default lane count
//   - load_kind_e    : what the output register does on a given cycle
//   - keep_bit       : one bit of a keep mask (lane is below the fill level)
// ----------------------------------------------------------------------------
package fifo_pack_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_LANES      = 4;

  // Ceiling log2; clog2(1) = 0.
  function automatic integer clog2(input integer value);
    integer v;
    integer r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  localparam int LANE_IDX_W = clog2(DEFAULT_LANES);

  // Output register action selected each cycle.
  typedef enum logic [1:0] {
    LOAD_NONE    = 2'd0,  // hold contents and valid
    LOAD_FULL    = 2'd1,  // complete word from the final-lane pop
    LOAD_PARTIAL = 2'd2,  // flushed partial word
    LOAD_DRAIN   = 2'd3   // beat accepted, nothing new: drop valid
  } load_kind_e;

  // Keep-mask bit for 'lane' when 'filled' lanes hold data: (1<<filled)-1.
  function automatic logic keep_bit(input int lane, input int filled);
    return (lane < filled) ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/fifo_word_packer.sv
// ----------------------------------------------------------------------------
// fifo_word_packer
// Drains the show-ahead read port of async_fifo and packs LANES consecutive
// entries into one wide word on a valid/ready stream. A flush pulse emits the
// partially filled word (unused lanes zero, out_last=1).
//
// Ports:
//   read_clk      in   FIFO read clock; the whole block runs on it
//   read_reset_n  in   asynchronous active-low reset
//   fifo_empty    in   FIFO empty flag
//   fifo_data     in   FIFO head entry, valid whenever fifo_empty=0
//   fifo_read_en  out  pop request (combinational, 0 during reset)
//   flush         in   single-cycle partial-word flush request
//   out_valid     out  output word valid
//   out_ready     in   downstream accept
//   out_data      out  packed word, lane 0 = first-popped entry in the LSBs
//   out_keep      out  per-lane valid mask
//   out_last      out  beat produced by a flush
//   flush_busy    out  flush accepted but not yet completed
// ----------------------------------------------------------------------------
module fifo_word_packer
  import fifo_pack_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int LANES      = DEFAULT_LANES
) (
  input  logic                        read_clk,
  input  logic                        read_reset_n,
  input  logic                        fifo_empty,
  input  logic [DATA_WIDTH-1:0]       fifo_data,
  output logic                        fifo_read_en,
  input  logic                        flush,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_WIDTH*LANES-1:0] out_data,
  output logic [LANES-1:0]            out_keep,
  output logic                        out_last,
  output logic                        flush_busy
);

  localparam int                IDX_W     = clog2(LANES);
  localparam int                ACC_W     = DATA_WIDTH * (LANES - 1);
  localparam logic [IDX_W-1:0]  LAST_LANE = IDX_W'(LANES - 1);
  localparam logic [IDX_W-1:0]  IDX_ZERO  = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);

  // Registered state
  logic [ACC_W-1:0]             acc_r;
  logic [IDX_W-1:0]             lane_idx_r;
  logic                         flush_pending_r;
  logic                         out_valid_r;
  logic [DATA_WIDTH*LANES-1:0]  out_data_r;
  logic [LANES-1:0]             out_keep_r;
  logic                         out_last_r;

  // Combinational decisions
  logic                         out_free_s;
  logic                         last_lane_s;
  logic                         pop_s;
  load_kind_e                   load_kind_s;
  logic [IDX_W-1:0]             lane_idx_nxt_s;
  logic                         flush_pending_nxt_s;
  logic [ACC_W-1:0]             partial_acc_s;
  logic [LANES-1:0]             keep_partial_s;

  // Pop decision, output-register action and next lane/flush state.
  always_comb begin
    out_free_s          = !out_valid_r || out_ready;
    last_lane_s         = (lane_idx_r == LAST_LANE);
    // The final lane can only be popped when the output register can take it.
    pop_s               = !fifo_empty && !flush_pending_r && (!last_lane_s || out_free_s);
    load_kind_s         = LOAD_NONE;
    lane_idx_nxt_s      = lane_idx_r;
    flush_pending_nxt_s = flush_pending_r;

    // pop_s and flush_pending_r never coexist, so the branches are exclusive.
    if (pop_s && last_lane_s) begin
      load_kind_s = LOAD_FULL;
    end else if (flush_pending_r && (lane_idx_r != IDX_ZERO) && out_free_s) begin
      load_kind_s = LOAD_PARTIAL;
    end else if (out_ready) begin
      load_kind_s = LOAD_DRAIN;
    end else begin
      load_kind_s = LOAD_NONE;
    end

    if (pop_s) begin
      lane_idx_nxt_s = last_lane_s ? IDX_ZERO : (lane_idx_r + IDX_ONE);
    end else if (load_kind_s == LOAD_PARTIAL) begin
      lane_idx_nxt_s = IDX_ZERO;
    end else begin
      lane_idx_nxt_s = lane_idx_r;
    end

    // A pending flush finishes immediately when nothing is accumulated,
    // otherwise when its partial word is loaded. New pulses are ignored
    // while one is pending.
    if (flush_pending_r) begin
      if ((lane_idx_r == IDX_ZERO) || (load_kind_s == LOAD_PARTIAL)) begin
        flush_pending_nxt_s = 1'b0;
      end else begin
        flush_pending_nxt_s = 1'b1;
      end
    end else if (flush) begin
      flush_pending_nxt_s = 1'b1;
    end else begin
      flush_pending_nxt_s = 1'b0;
    end
  end

  // Partial word: lanes at or above the fill level are forced to zero.
  always_comb begin
    partial_acc_s  = {ACC_W{1'b0}};
    keep_partial_s = {LANES{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      keep_partial_s[i] = keep_bit(i, 32'(lane_idx_r));
    end
    for (int i = 0; i < LANES - 1; i++) begin
      if (keep_partial_s[i]) begin
        partial_acc_s[i*DATA_WIDTH +: DATA_WIDTH] = acc_r[i*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        partial_acc_s[i*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{1'b0}};
      end
    end
  end

  // Accumulator lanes; the final lane goes straight to the output register.
  always_ff @(posedge read_clk or negedge read_reset_n) begin
    if (!read_reset_n) begin
      acc_r <= {ACC_W{1'b0}};
    end else begin
      for (int i = 0; i < LANES - 1; i++) begin
        if (pop_s && !last_lane_s && (lane_idx_r == IDX_W'(i))) begin
          acc_r[i*DATA_WIDTH +: DATA_WIDTH] <= fifo_data;
        end
      end
    end
  end

  // Lane index and flush-pending state.
  always_ff @(posedge read_clk or negedge read_reset_n) begin
    if (!read_reset_n) begin
      lane_idx_r      <= IDX_ZERO;
      flush_pending_r <= 1'b0;
    end else begin
      lane_idx_r      <= lane_idx_nxt_s;
      flush_pending_r <= flush_pending_nxt_s;
    end
  end

  // Output register: loads only when free, otherwise holds the beat stable.
  always_ff @(posedge read_clk or negedge read_reset_n) begin
    if (!read_reset_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {(DATA_WIDTH*LANES){1'b0}};
      out_keep_r  <= {LANES{1'b0}};
      out_last_r  <= 1'b0;
    end else begin
      case (load_kind_s)
        LOAD_FULL: begin
          out_valid_r <= 1'b1;
          out_data_r  <= {fifo_data, acc_r};
          out_keep_r  <= {LANES{1'b1}};
          out_last_r  <= 1'b0;
        end
        LOAD_PARTIAL: begin
          out_valid_r <= 1'b1;
          out_data_r  <= {{DATA_WIDTH{1'b0}}, partial_acc_s};
          out_keep_r  <= keep_partial_s;
          out_last_r  <= 1'b1;
        end
        LOAD_DRAIN: begin
          out_valid_r <= 1'b0;
        end
        LOAD_NONE: begin
          out_valid_r <= out_valid_r;
        end
        default: begin
          out_valid_r <= out_valid_r;
        end
      endcase
    end
  end

  assign fifo_read_en = pop_s && read_reset_n;
  assign out_valid    = out_valid_r;
  assign out_data     = out_data_r;
  assign out_keep     = out_keep_r;
  assign out_last     = out_last_r;
  assign flush_busy   = flush_pending_r;

endmodule

// File: tb/tb_fifo_word_packer.sv
// ----------------------------------------------------------------------------
// tb_fifo_word_packer
// Self-checking bench: a queue stands in for the show-ahead FIFO, a reference
// model groups popped entries into words (and flushed partial words), and a
// monitor compares every accepted beat against the expected-beat queue.
// ----------------------------------------------------------------------------
module tb_fifo_word_packer;

  localparam int DW    = 8;
  localparam int LANES = 4;

  typedef struct packed {
    logic [DW*LANES-1:0] data;
    logic [LANES-1:0]    keep;
    logic                last;
  } beat_t;

  logic                read_clk = 1'b0;
  logic                read_reset_n;
  logic                fifo_empty;
  logic [DW-1:0]       fifo_data;
  logic                fifo_read_en;
  logic                flush;
  logic                out_valid;
  logic                out_ready;
  logic [DW*LANES-1:0] out_data;
  logic [LANES-1:0]    out_keep;
  logic                out_last;
  logic                flush_busy;

  fifo_word_packer #(.DATA_WIDTH(DW), .LANES(LANES)) dut (
    .read_clk     (read_clk),
    .read_reset_n (read_reset_n),
    .fifo_empty   (fifo_empty),
    .fifo_data    (fifo_data),
    .fifo_read_en (fifo_read_en),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_keep     (out_keep),
    .out_last     (out_last),
    .flush_busy   (flush_busy)
  );

  always #5 read_clk = ~read_clk;

  logic [DW-1:0] src_q[$];   // FIFO contents, head = src_q[0]
  logic [DW-1:0] part_q[$];  // model: entries popped but not yet in a word
  beat_t         exp_q[$];   // model: expected beats in order
  int            checks   = 0;
  int            failures = 0;
  bit            ready_ctl  = 1'b0;
  bit            hold_empty = 1'b0;
  bit            last_pop   = 1'b0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Turn whatever the model has accumulated into one expected beat.
  function automatic void emit(bit last);
    beat_t b;
    b = '0;
    b.last = last;
    for (int i = 0; i < part_q.size(); i++) begin
      b.data[i*DW +: DW] = part_q[i];
      b.keep[i] = 1'b1;
    end
    exp_q.push_back(b);
    part_q.delete();
  endfunction

  function automatic void model_pop(logic [DW-1:0] d);
    part_q.push_back(d);
    if (part_q.size() == LANES) emit(1'b0);
  endfunction

  // One clock: drive inputs at the falling edge, observe the pop decision
  // shortly after, and account for it in the model.
  task automatic cycle(bit do_flush);
    bit fl;
    @(negedge read_clk);
    read_reset_n = 1'b1;
    out_ready    = ready_ctl;
    fifo_empty   = hold_empty || (src_q.size() == 0);
    fifo_data    = fifo_empty ? DW'($urandom) : src_q[0];
    fl           = do_flush && !flush_busy;
    flush        = fl;
    #1;
    last_pop = fifo_read_en;
    if (fifo_read_en) begin
      if (fifo_empty) begin
        check("pop_while_empty", 64'(fifo_read_en), 64'(0));
      end else begin
        model_pop(src_q.pop_front());
      end
    end
    if (fl && (part_q.size() != 0)) emit(1'b1);
  endtask

  task automatic reset_pulse();
    @(negedge read_clk);
    read_reset_n = 1'b0;
    flush        = 1'b0;
    out_ready    = ready_ctl;
    fifo_empty   = (src_q.size() == 0);
    fifo_data    = fifo_empty ? DW'(0) : src_q[0];
    #1;
    check("rst_out_valid",  64'(out_valid),    64'(0));
    check("rst_out_data",   64'(out_data),     64'(0));
    check("rst_out_keep",   64'(out_keep),     64'(0));
    check("rst_out_last",   64'(out_last),     64'(0));
    check("rst_flush_busy", 64'(flush_busy),   64'(0));
    check("rst_read_en",    64'(fifo_read_en), 64'(0));
    part_q.delete();
    exp_q.delete();
  endtask

  // Monitor: every accepted beat must match the head of the expected queue.
  initial begin
    beat_t e;
    forever begin
      @(negedge read_clk);
      #2;
      if (read_reset_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 64'(out_data), 64'(0));
          if (out_data == '0) begin
            failures++;
            $display("FAIL unexpected_beat actual=valid expected=no_beat");
          end
        end else begin
          e = exp_q.pop_front();
          check("beat_data", 64'(out_data), 64'(e.data));
          check("beat_keep", 64'(out_keep), 64'(e.keep));
          check("beat_last", 64'(out_last), 64'(e.last));
        end
      end
    end
  end

  initial begin
    read_reset_n = 1'b1;
    fifo_empty   = 1'b1;
    fifo_data    = '0;
    flush        = 1'b0;
    out_ready    = 1'b0;
    #1;

    // Reset state, with entries waiting in the FIFO.
    src_q = '{8'h00, 8'h44, 8'h88, 8'hCC};
    reset_pulse();

    // Full word: four pops, valid the cycle after the fourth.
    ready_ctl = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0);
      check("full_pop", 64'(last_pop), 64'(1));
      check("full_not_yet_valid", 64'(out_valid), 64'(0));
    end
    cycle(1'b0);
    check("full_latency_valid", 64'(out_valid), 64'(1));
    check("full_word_data", 64'(out_data), 64'(32'hCC884400));
    repeat (2) cycle(1'b0);

    // Backpressure: one word held, three more popped, then stall.
    ready_ctl = 1'b0;
    for (int i = 1; i <= 8; i++) src_q.push_back(DW'(i));
    repeat (10) cycle(1'b0);
    check("bp_read_en_stalled", 64'(last_pop), 64'(0));
    check("bp_fifo_left", 64'(src_q.size()), 64'(1));
    check("bp_held_data", 64'(out_data), 64'(32'h04030201));
    ready_ctl = 1'b1;
    repeat (4) cycle(1'b0);

    // Partial flush.
    src_q = '{8'hA1, 8'hB2};
    repeat (2) cycle(1'b0);
    cycle(1'b1);
    cycle(1'b0);
    check("pflush_busy_high", 64'(flush_busy), 64'(1));
    cycle(1'b0);
    check("pflush_busy_low", 64'(flush_busy), 64'(0));
    check("pflush_out_last", 64'(out_last), 64'(1));
    repeat (2) cycle(1'b0);

    // Empty flush: busy exactly one cycle, no beat.
    cycle(1'b1);
    cycle(1'b0);
    check("eflush_busy_high", 64'(flush_busy), 64'(1));
    cycle(1'b0);
    check("eflush_busy_low", 64'(flush_busy), 64'(0));
    check("eflush_no_beat", 64'(out_valid), 64'(0));

    // Flush while the output register is blocked.
    ready_ctl = 1'b0;
    src_q = '{8'hD0, 8'hD1, 8'hD2, 8'hD3, 8'hD4, 8'hD5, 8'hD6, 8'hE0};
    repeat (9) cycle(1'b0);
    cycle(1'b1);
    cycle(1'b0);
    check("bflush_no_pop_blocked", 64'(last_pop), 64'(0));
    ready_ctl = 1'b1;
    cycle(1'b0);
    check("bflush_no_pop_pending", 64'(last_pop), 64'(0));
    cycle(1'b0);
    check("bflush_resume_pop", 64'(last_pop), 64'(1));
    repeat (2) cycle(1'b0);
    cycle(1'b1);
    repeat (4) cycle(1'b0);

    // Reset mid-word discards popped entries.
    src_q = '{8'h20, 8'h21};
    repeat (2) cycle(1'b0);
    src_q = '{8'h10, 8'h11, 8'h12, 8'h13};
    reset_pulse();
    repeat (7) cycle(1'b0);
    check("rst_word_consumed", 64'(src_q.size()), 64'(0));

    // Randomized traffic with gaps, backpressure and flushes.
    for (int n = 0; n < 1500; n++) begin
      ready_ctl  = ($urandom_range(0, 9) < 7);
      hold_empty = ($urandom_range(0, 9) < 2);
      if ((src_q.size() < 6) && ($urandom_range(0, 1) == 1)) src_q.push_back(DW'($urandom));
      cycle($urandom_range(0, 19) == 0);
    end

    // Drain everything, bounded.
    ready_ctl  = 1'b1;
    hold_empty = 1'b0;
    for (int n = 0; (n < 200) && (src_q.size() != 0); n++) cycle(1'b0);
    check("rand_fifo_drained", 64'(src_q.size()), 64'(0));
    repeat (10) cycle(1'b0);
    cycle(1'b1);
    repeat (10) cycle(1'b0);
    check("rand_scoreboard_empty", 64'(exp_q.size()), 64'(0));
    check("rand_idle_valid", 64'(out_valid), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
